// File: rtl/cam_pkg.sv
// cam_pkg: shared CAM request/response types, command opcodes and client FSM states.
package cam_pkg;

    localparam int CAM_KEY_WIDTH = 32;
    localparam int CAM_KEY_DEPTH = 16;
    localparam int CAM_AW        = $clog2(CAM_KEY_DEPTH);

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        READ   = 2'b01,
        WRITE  = 2'b10,
        RSVD   = 2'b11
    } cam_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } cam_state_e;

    typedef struct packed {
        logic                     we;
        logic                     addr_vld;
        logic                     data_vld;
        logic [CAM_AW-1:0]        addr;
        logic [CAM_KEY_WIDTH-1:0] data;
    } cam_req_t;

    typedef struct packed {
        logic                     addr_vld;
        logic [CAM_AW-1:0]        addr;
        logic [CAM_KEY_WIDTH-1:0] data;
    } cam_resp_t;

endpackage

// File: rtl/cam_client_stats.sv
// cam_client_stats: saturating 32-bit hit/miss counters, bumped once per result.
module cam_client_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        evt,
    input  logic        hit,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    // Each result lands in exactly one bucket; both buckets stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (evt && hit && !(&hit_cnt))
                hit_cnt <= hit_cnt + 32'd1;
            if (evt && !hit && !(&miss_cnt))
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/cam_client.sv
// cam_client: single-outstanding CAM/TCAM initiator, command -> one-cycle cam_req -> result beat.
// Defining CAM_CLIENT_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module cam_client
    import cam_pkg::*;
#(
    parameter int  KEY_WIDTH    = CAM_KEY_WIDTH,
    parameter int  KEY_DEPTH    = CAM_KEY_DEPTH,
    parameter int  RESP_TIMEOUT = 4,
    localparam int AW           = $clog2(KEY_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_vld,
    output logic                 cmd_rdy,
    input  logic [1:0]           cmd_op,
    input  logic [AW-1:0]        cmd_addr,
    input  logic [KEY_WIDTH-1:0] cmd_data,
    output cam_req_t             cam_req,
    input  cam_resp_t            cam_resp,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output logic [1:0]           res_op,
    output logic                 res_hit,
    output logic [AW-1:0]        res_addr,
    output logic [KEY_WIDTH-1:0] res_data
`ifdef CAM_CLIENT_STATS_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
`endif
);

    localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

    if (RESP_TIMEOUT < 1) begin : g_bad_timeout
        $error("cam_client: RESP_TIMEOUT must be >= 1");
    end

    if (KEY_WIDTH != CAM_KEY_WIDTH || AW != CAM_AW) begin : g_bad_geometry
        $error("cam_client: KEY_WIDTH/KEY_DEPTH must match the cam_pkg request/response types");
    end

    cam_state_e           state, state_n;
    cam_op_e              op_q, src_op;
    logic [AW-1:0]        addr_q, src_addr;
    logic [KEY_WIDTH-1:0] data_q, src_data;
    logic [TW-1:0]        timer;
    logic                 enter_resp, hit_n;

    assign cmd_rdy    = state == IDLE && !rst;
    assign hit_n      = state == WAIT && cam_resp.addr_vld;
    assign enter_resp = state != RESP && state_n == RESP;
    // A reserved op is answered straight from the command bus; everything else from the latch.
    assign src_op     = state == IDLE ? cam_op_e'(cmd_op) : op_q;
    assign src_addr   = state == IDLE ? cmd_addr : addr_q;
    assign src_data   = state == IDLE ? cmd_data : data_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next state and the cam_req pulse, which only exists during ISSUE.
    always_comb begin
        state_n = state;
        cam_req = '0;
        case (state)
            IDLE: begin
                if (cmd_vld && cmd_rdy)
                    state_n = cam_op_e'(cmd_op) == RSVD ? RESP : ISSUE;
            end
            ISSUE: begin
                cam_req.we       = op_q == WRITE;
                cam_req.addr_vld = op_q != SEARCH;
                cam_req.data_vld = op_q != READ;
                cam_req.addr     = addr_q;
                cam_req.data     = data_q;
                state_n          = op_q == WRITE ? IDLE : WAIT;
            end
            WAIT: begin
                if (cam_resp.addr_vld || timer == TW'(RESP_TIMEOUT - 1))
                    state_n = RESP;
            end
            RESP: begin
                if (res_rdy)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Command latch, WAIT timer and the registered result beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= SEARCH;
            addr_q   <= '0;
            data_q   <= '0;
            timer    <= '0;
            res_vld  <= 1'b0;
            res_op   <= '0;
            res_hit  <= 1'b0;
            res_addr <= '0;
            res_data <= '0;
        end else begin
            if (cmd_vld && cmd_rdy) begin
                op_q   <= cam_op_e'(cmd_op);
                addr_q <= cmd_addr;
                data_q <= cmd_data;
            end
            timer <= state == WAIT ? timer + 1'b1 : '0;
            if (enter_resp) begin
                res_vld  <= 1'b1;
                res_op   <= src_op;
                res_hit  <= hit_n;
                res_addr <= hit_n ? cam_resp.addr : src_addr;
                res_data <= hit_n ? cam_resp.data : src_data;
            end else if (state == RESP && res_rdy) begin
                res_vld <= 1'b0;
            end
        end
    end

`ifdef CAM_CLIENT_STATS_EN
    cam_client_stats u_stats (
        .clk      (clk),
        .rst      (rst),
        .evt      (enter_resp),
        .hit      (hit_n),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );
`endif

endmodule

// File: tb/tb_cam_client.sv
// tb_cam_client: table-driven, scoreboarded bench for cam_client; checks counters when CAM_CLIENT_STATS_EN is defined.
module tb_cam_client;
    import cam_pkg::*;

    localparam int TO = 4;

    typedef struct packed {
        logic [1:0]  op;
        logic        hit;
        logic [3:0]  addr;
        logic [31:0] data;
    } res_t;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [31:0] data;
        int          resp_at;
        logic [3:0]  resp_addr;
        logic [31:0] resp_data;
        int          hold;
        logic [2:0]  exp_req;
        logic        has_res;
        logic        exp_hit;
        logic [3:0]  exp_addr;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_data;
    cam_req_t    cam_req;
    cam_resp_t   cam_resp;
    logic        res_vld;
    logic        res_rdy;
    logic [1:0]  res_op;
    logic        res_hit;
    logic [3:0]  res_addr;
    logic [31:0] res_data;
`ifdef CAM_CLIENT_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    int          exp_hits = 0;
    int          exp_miss = 0;
`endif

    int       n_cmp = 0;
    int       n_err = 0;
    cam_req_t req_q[$];
    res_t     res_q[$];
    vec_t     vecs[9];

    cam_client #(.KEY_WIDTH(32), .KEY_DEPTH(16), .RESP_TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .cam_req  (cam_req),
        .cam_resp (cam_resp),
        .res_vld  (res_vld),
        .res_rdy  (res_rdy),
        .res_op   (res_op),
        .res_hit  (res_hit),
        .res_addr (res_addr),
        .res_data (res_data)
`ifdef CAM_CLIENT_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Waits for the sampling edge and scores any cam_req pulse or result handshake seen there.
    task automatic sample();
        cam_req_t rq;
        res_t     rs;
        @(negedge clk);
        if (!rst) begin
            if (cam_req.we || cam_req.addr_vld || cam_req.data_vld) begin
                chk("cam_req expected", 64'(req_q.size() != 0), 64'd1);
                if (req_q.size() != 0) begin
                    rq = req_q.pop_front();
                    chk("cam_req fields", 64'(cam_req), 64'(rq));
                end
            end
            if (res_vld && res_rdy) begin
                chk("result expected", 64'(res_q.size() != 0), 64'd1);
                if (res_q.size() != 0) begin
                    rs = res_q.pop_front();
                    chk("result fields", 64'({res_op, res_hit, res_addr, res_data}), 64'(rs));
                end
            end
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [31:0] d);
        bit ok;
        ok       = 1'b0;
        cmd_vld  = 1'b1;
        cmd_op   = op;
        cmd_addr = a;
        cmd_data = d;
        for (int k = 0; k < 10 && !ok; k++) begin
            sample();
            ok = cmd_rdy;
            @(posedge clk);
            #1;
        end
        cmd_vld = 1'b0;
        chk("cmd accepted", 64'(ok), 64'd1);
    endtask

    // Runs one table row: cycle c counts from the cycle right after the accepting edge.
    task automatic run_vec(input int i);
        vec_t     v;
        cam_req_t rq;
        res_t     rs;
        res_t     snap;
        int       first;
        bit       done;
        v     = vecs[i];
        first = -1;
        done  = 1'b0;
        snap  = '0;
        if (v.exp_req != 3'b000) begin
            rq = '{we: v.exp_req[2], addr_vld: v.exp_req[1], data_vld: v.exp_req[0], addr: v.addr, data: v.data};
            req_q.push_back(rq);
        end
        if (v.has_res) begin
            rs = '{op: v.op, hit: v.exp_hit, addr: v.exp_addr, data: v.exp_data};
            res_q.push_back(rs);
`ifdef CAM_CLIENT_STATS_EN
            if (v.exp_hit)
                exp_hits++;
            else
                exp_miss++;
`endif
        end
        issue(v.op, v.addr, v.data);
        for (int c = 0; c < 30 && !done; c++) begin
            if (v.resp_at >= 0 && c == v.resp_at + 1)
                cam_resp = '{addr_vld: 1'b1, addr: v.resp_addr, data: v.resp_data};
            else
                cam_resp = '0;
            res_rdy = (v.hold == 0) || (first >= 0 && c - first >= v.hold);
            sample();
            if (c == 0)
                chk($sformatf("v%0d req flags", i), 64'({cam_req.we, cam_req.addr_vld, cam_req.data_vld}), 64'(v.exp_req));
            if (c == 1)
                chk($sformatf("v%0d req cleared", i), 64'(cam_req), 64'd0);
            if (!v.has_res && c < 2)
                chk($sformatf("v%0d write cmd_rdy c%0d", i, c), 64'(cmd_rdy), 64'(c == 1));
            if (res_vld) begin
                chk($sformatf("v%0d cmd_rdy busy", i), 64'(cmd_rdy), 64'd0);
                if (first < 0) begin
                    first = c;
                    snap  = {res_op, res_hit, res_addr, res_data};
                    chk($sformatf("v%0d latency", i), 64'(c), 64'(v.exp_lat));
                end else begin
                    chk($sformatf("v%0d stable", i), 64'({res_op, res_hit, res_addr, res_data}), 64'(snap));
                end
                if (res_rdy)
                    done = 1'b1;
            end
            if (!v.has_res) begin
                chk($sformatf("v%0d no beat", i), 64'(res_vld), 64'd0);
                if (c == 3)
                    done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        cam_resp = '0;
        res_rdy  = 1'b1;
        if (v.has_res)
            chk($sformatf("v%0d beat delivered", i), 64'(done), 64'd1);
    endtask

    initial begin
        rst      = 1'b1;
        cmd_vld  = 1'b0;
        cmd_op   = 2'b00;
        cmd_addr = '0;
        cmd_data = '0;
        cam_resp = '0;
        res_rdy  = 1'b1;

        //            op     addr   data           rsp  raddr  rdata          hold req     res  hit  eaddr  edata          lat
        vecs[0] = '{2'b10, 4'd3,  32'hDEADBEEF, -1, 4'd0,  32'h00000000, 0, 3'b111, 1'b0, 1'b0, 4'd0,  32'h00000000, 0};
        vecs[1] = '{2'b00, 4'd0,  32'hDEADBEEF,  0, 4'd3,  32'hDEADBEEF, 0, 3'b001, 1'b1, 1'b1, 4'd3,  32'hDEADBEEF, 2};
        vecs[2] = '{2'b00, 4'd6,  32'h12345678, -1, 4'd0,  32'h00000000, 0, 3'b001, 1'b1, 1'b0, 4'd6,  32'h12345678, 5};
        vecs[3] = '{2'b01, 4'd3,  32'h00000000,  1, 4'd3,  32'hDEADBEEF, 5, 3'b010, 1'b1, 1'b1, 4'd3,  32'hDEADBEEF, 3};
        vecs[4] = '{2'b00, 4'd2,  32'hCAFEF00D,  3, 4'd7,  32'hCAFEF00D, 0, 3'b001, 1'b1, 1'b1, 4'd7,  32'hCAFEF00D, 5};
        vecs[5] = '{2'b11, 4'd9,  32'hA5A5A5A5, -1, 4'd0,  32'h00000000, 0, 3'b000, 1'b1, 1'b0, 4'd9,  32'hA5A5A5A5, 0};
        vecs[6] = '{2'b01, 4'd15, 32'h00000000,  2, 4'd15, 32'h0BADF00D, 0, 3'b010, 1'b1, 1'b1, 4'd15, 32'h0BADF00D, 4};
        vecs[7] = '{2'b10, 4'd0,  32'hFFFFFFFF, -1, 4'd0,  32'h00000000, 0, 3'b111, 1'b0, 1'b0, 4'd0,  32'h00000000, 0};
        vecs[8] = '{2'b01, 4'd5,  32'h00000000,  4, 4'd5,  32'h77777777, 0, 3'b010, 1'b1, 1'b0, 4'd5,  32'h00000000, 5};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset cmd_rdy", 64'(cmd_rdy), 64'd0);
        chk("reset res_vld", 64'(res_vld), 64'd0);
        chk("reset cam_req", 64'(cam_req), 64'd0);
        chk("reset res fields", 64'({res_op, res_hit, res_addr, res_data}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sample();
        chk("idle cmd_rdy", 64'(cmd_rdy), 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++)
            run_vec(i);

        // Stray response while idle must be dropped.
        cam_resp = '{addr_vld: 1'b1, addr: 4'd2, data: 32'h11111111};
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("stray res_vld", 64'(res_vld), 64'd0);
            chk("stray cmd_rdy", 64'(cmd_rdy), 64'd1);
            @(posedge clk);
            #1;
        end
        cam_resp = '0;
        run_vec(1);

`ifdef CAM_CLIENT_STATS_EN
        sample();
        chk("hit_cnt", 64'(hit_cnt), 64'(exp_hits));
        chk("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
        @(posedge clk);
        #1;
`endif

        // Reset while waiting on the cam: the command vanishes without a beat.
        begin
            cam_req_t rq;
            rq = '{we: 1'b0, addr_vld: 1'b0, data_vld: 1'b1, addr: 4'd1, data: 32'h55AA55AA};
            req_q.push_back(rq);
        end
        issue(2'b00, 4'd1, 32'h55AA55AA);
        sample();
        @(posedge clk);
        #1;
        sample();
        chk("wait res_vld", 64'(res_vld), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sample();
        chk("midrst cmd_rdy", 64'(cmd_rdy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sample();
        chk("postrst cmd_rdy", 64'(cmd_rdy), 64'd1);
        chk("postrst res_vld", 64'(res_vld), 64'd0);
        chk("postrst cam_req", 64'(cam_req), 64'd0);
`ifdef CAM_CLIENT_STATS_EN
        chk("postrst hit_cnt", 64'(hit_cnt), 64'd0);
        chk("postrst miss_cnt", 64'(miss_cnt), 64'd0);
`endif
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            sample();
            chk("postrst no beat", 64'(res_vld), 64'd0);
        end

        chk("req queue drained", 64'(req_q.size()), 64'd0);
        chk("res queue drained", 64'(res_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
